// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, AXI responses,
// writeback error codes and the latched request record.
package ysyx_25040111_lsu_pkg;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_BYTE = 2'b01;
    localparam logic [1:0] MASK_HALF = 2'b10;
    localparam logic [1:0] MASK_WORD = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_TMO      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } lsu_state_e;

    // GPR value and enable live in their own registers since loads/faults rewrite them.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        rsign;
        logic [4:0]  ard;
        logic [11:0] acsr;
        logic [31:0] csr;
        logic        sen;
    } lsu_req_t;

    function automatic logic misaligned(input logic [1:0] mask, input logic [1:0] lo);
        return (mask == MASK_HALF && lo[0]) || (mask == MASK_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Byte-lane steering: store data/strobe shifted into the addressed lanes,
// load data pulled down from its lanes and zero/sign extended.
module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mask,
    input  logic        rsign,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [4:0]  sh;
    logic [3:0]  strb_base;
    logic [31:0] ld_shift;

    assign sh       = {addr_lo, 3'b000};
    assign st_wdata = st_data << sh;
    assign st_wstrb = strb_base << addr_lo;
    assign ld_shift = ld_rdata >> sh;

    always_comb begin
        strb_base = 4'b0000;
        case (mask)
            MASK_BYTE: strb_base = 4'b0001;
            MASK_HALF: strb_base = 4'b0011;
            MASK_WORD: strb_base = 4'b1111;
            default:   strb_base = 4'b0000;
        endcase
    end

    always_comb begin
        ld_data = ld_shift;
        case (mask)
            MASK_BYTE: ld_data = {{24{rsign & ld_shift[7]}}, ld_shift[7:0]};
            MASK_HALF: ld_data = {{16{rsign & ld_shift[15]}}, ld_shift[15:0]};
            default:   ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Load/store stage: one instruction in flight, one AXI4-Lite transaction per memory op,
// optional bus timeout, writeback payload held until the next stage takes it.
module ysyx_25040111_lsu
    import ysyx_25040111_lsu_pkg::*;
#(
    parameter int TMO_W  = 8,
    parameter bit TMO_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        abt_valid,
    output logic        abt_ready,
    input  logic        abt_men,
    input  logic        abt_write,
    input  logic [31:0] abt_addr,
    input  logic [31:0] abt_wdata,
    input  logic [1:0]  abt_mask,
    input  logic        abt_rsign,
    input  logic [4:0]  abt_ard,
    input  logic [31:0] abt_rd,
    input  logic        abt_gen,
    input  logic [11:0] abt_acsr,
    input  logic [31:0] abt_csr,
    input  logic        abt_sen,
    output logic        wbu_valid,
    input  logic        wbu_ready,
    output logic [4:0]  wbu_ard,
    output logic [31:0] wbu_rd,
    output logic        wbu_gen,
    output logic [11:0] wbu_acsr,
    output logic [31:0] wbu_csr,
    output logic        wbu_sen,
    output logic [1:0]  wbu_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    // Abort fires on the TMO_MAX-th stalled cycle of a wait state (counter starts at 0).
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    lsu_state_e       state, state_n;
    lsu_req_t         req;
    logic [31:0]      rd_q;
    logic             gen_q;
    logic [1:0]       err_q;
    logic             aw_done, w_done;
    logic [TMO_W-1:0] tmo_cnt;
    logic             accept, mis_in, aw_fire, w_fire, r_fire, b_fire, tmo_hit, abort;
    logic [31:0]      ld_data;

    assign abt_ready = (state == S_IDLE);
    assign accept    = abt_valid & abt_ready;
    assign mis_in    = abt_men && abt_mask != MASK_NONE && misaligned(abt_mask, abt_addr[1:0]);

    assign araddr  = {req.addr[31:2], 2'b00};
    assign awaddr  = {req.addr[31:2], 2'b00};
    assign arvalid = (state == S_RADDR);
    assign rready  = (state == S_RDATA);
    assign awvalid = (state == S_WREQ) && !aw_done;
    assign wvalid  = (state == S_WREQ) && !w_done;
    assign bready  = (state == S_WRESP);

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign r_fire  = rready & rvalid;
    assign b_fire  = bready & bvalid;
    assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

    assign wbu_valid = (state == S_DONE);
    assign wbu_ard   = req.ard;
    assign wbu_rd    = rd_q;
    assign wbu_gen   = gen_q;
    assign wbu_acsr  = req.acsr;
    assign wbu_csr   = req.csr;
    assign wbu_sen   = req.sen;
    assign wbu_err   = err_q;

    ysyx_25040111_lsu_align u_align (
        .addr_lo  (req.addr[1:0]),
        .mask     (req.mask),
        .rsign    (req.rsign),
        .st_data  (req.wdata),
        .st_wdata (wdata),
        .st_wstrb (wstrb),
        .ld_rdata (rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_n = state;
        abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (abt_valid) begin
                    if (!abt_men || abt_mask == MASK_NONE || mis_in) state_n = S_DONE;
                    else if (abt_write)                              state_n = S_WREQ;
                    else                                             state_n = S_RADDR;
                end
            end
            S_RADDR: if (arready) state_n = S_RDATA; else abort = tmo_hit;
            S_RDATA: if (rvalid)  state_n = S_DONE;  else abort = tmo_hit;
            S_WREQ: begin
                if ((aw_done | aw_fire) & (w_done | w_fire)) state_n = S_WRESP;
                else abort = tmo_hit;
            end
            S_WRESP: if (bvalid)    state_n = S_DONE; else abort = tmo_hit;
            S_DONE:  if (wbu_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort) state_n = S_DONE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            req     <= '0;
            rd_q    <= '0;
            gen_q   <= 1'b0;
            err_q   <= ERR_OK;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            // Cleared on every state change, so each wait state starts its own window.
            tmo_cnt <= (state_n != state) ? '0 : tmo_cnt + TMO_W'(1);
            if (accept) begin
                req <= '{addr: abt_addr, wdata: abt_wdata, mask: abt_mask, rsign: abt_rsign,
                         ard: abt_ard, acsr: abt_acsr, csr: abt_csr, sen: abt_sen};
                rd_q    <= abt_rd;
                gen_q   <= abt_gen & ~mis_in;
                err_q   <= mis_in ? ERR_MISALIGN : ERR_OK;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
            if (r_fire) begin
                rd_q <= ld_data;
                if (rresp != RESP_OKAY) begin
                    err_q <= ERR_BUS;
                    gen_q <= 1'b0;
                end
            end
            if (b_fire && bresp != RESP_OKAY) err_q <= ERR_BUS;
            if (abort) begin
                err_q <= ERR_TMO;
                gen_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Randomized + directed bench for the LSU: a reactive AXI slave with per-transaction delays,
// an arithmetic reference model, and one negedge compare process.
module tb_ysyx_25040111_lsu;
    import ysyx_25040111_lsu_pkg::*;

    localparam int TMO_MAX = 255;

    logic clock = 1'b0, reset = 1'b0;
    logic abt_valid = 0, abt_men = 0, abt_write = 0, abt_rsign = 0, abt_gen = 0, abt_sen = 0;
    logic [31:0] abt_addr = 0, abt_wdata = 0, abt_rd = 0, abt_csr = 0;
    logic [1:0]  abt_mask = 0;
    logic [4:0]  abt_ard = 0;
    logic [11:0] abt_acsr = 0;
    logic abt_ready, wbu_valid, wbu_gen, wbu_sen;
    logic wbu_ready = 0;
    logic [4:0]  wbu_ard;
    logic [31:0] wbu_rd, wbu_csr;
    logic [11:0] wbu_acsr;
    logic [1:0]  wbu_err;
    logic [31:0] araddr, awaddr, wdata;
    logic arvalid, rready, awvalid, wvalid, bready;
    logic arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic [3:0]  wstrb;

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .abt_valid(abt_valid), .abt_ready(abt_ready), .abt_men(abt_men), .abt_write(abt_write),
        .abt_addr(abt_addr), .abt_wdata(abt_wdata), .abt_mask(abt_mask), .abt_rsign(abt_rsign),
        .abt_ard(abt_ard), .abt_rd(abt_rd), .abt_gen(abt_gen),
        .abt_acsr(abt_acsr), .abt_csr(abt_csr), .abt_sen(abt_sen),
        .wbu_valid(wbu_valid), .wbu_ready(wbu_ready), .wbu_ard(wbu_ard), .wbu_rd(wbu_rd),
        .wbu_gen(wbu_gen), .wbu_acsr(wbu_acsr), .wbu_csr(wbu_csr), .wbu_sen(wbu_sen),
        .wbu_err(wbu_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    // slave behaviour for the current transaction
    int ar_dly, r_dly, aw_dly, w_dly, b_dly, wb_dly;
    logic [31:0] rdata_v;
    logic [1:0]  rresp_v, bresp_v;

    // model expectations
    logic busy = 0, exp_bus_rd = 0, exp_bus_wr = 0, exp_gen = 0, exp_sen = 0;
    logic [31:0] exp_araddr = 0, exp_wdata = 0, exp_rd = 0, exp_csr = 0;
    logic [3:0]  exp_wstrb = 0;
    logic [1:0]  exp_err = 0;
    logic [4:0]  exp_ard = 0;
    logic [11:0] exp_acsr = 0;
    int exp_lat, exp_nar, exp_nr, exp_naw, exp_nw, exp_nb;

    // last values seen on the DUT during a transaction
    logic [31:0] cap_rd, cap_araddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [1:0]  cap_err;
    logic        cap_gen;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [1:0] m);
        return (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 4;
    endfunction

    // Reference load: take the addressed bytes, keep `size` of them, then sign extend by wrap.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [31:0] rd,
                                               input logic [1:0] m, input bit rs);
        logic [31:0] v, lim;
        int n;
        n = size_of(m);
        v = rd >> (8 * int'(addr[1:0]));
        if (n < 4) begin
            lim = 32'd1 << (8 * n);
            v = v % lim;
            if (rs && v >= lim / 2) v = v - lim;
        end
        return v;
    endfunction

    task automatic predict();
        int n, m;
        logic mem, mis;
        mem = abt_men && abt_mask != 2'b00;
        n   = size_of(abt_mask);
        mis = mem && (abt_addr % n != 0);
        exp_bus_rd = mem && !mis && !abt_write;
        exp_bus_wr = mem && !mis && abt_write;
        exp_araddr = abt_addr & ~32'h3;
        exp_wdata  = abt_wdata << (8 * int'(abt_addr[1:0]));
        exp_wstrb  = 4'(((1 << n) - 1) << int'(abt_addr[1:0]));
        exp_rd = abt_rd; exp_gen = abt_gen; exp_err = 2'b00; exp_ard = abt_ard;
        exp_acsr = abt_acsr; exp_csr = abt_csr; exp_sen = abt_sen;
        exp_lat = 0; exp_nar = 0; exp_nr = 0; exp_naw = 0; exp_nw = 0; exp_nb = 0;
        if (mis) begin
            exp_err = 2'b01; exp_gen = 0;
        end else if (exp_bus_rd) begin
            if (ar_dly >= TMO_MAX) begin
                exp_err = 2'b11; exp_gen = 0; exp_lat = TMO_MAX;
            end else if (r_dly >= TMO_MAX) begin
                exp_err = 2'b11; exp_gen = 0; exp_lat = ar_dly + 1 + TMO_MAX; exp_nar = 1;
            end else begin
                exp_nar = 1; exp_nr = 1; exp_lat = ar_dly + r_dly + 2;
                exp_rd = model_load(abt_addr, rdata_v, abt_mask, abt_rsign);
                if (rresp_v != RESP_OKAY) begin exp_err = 2'b10; exp_gen = 0; end
            end
        end else if (exp_bus_wr) begin
            m = (aw_dly > w_dly) ? aw_dly : w_dly;
            exp_naw = (aw_dly < TMO_MAX); exp_nw = (w_dly < TMO_MAX);
            if (m >= TMO_MAX) begin
                exp_err = 2'b11; exp_gen = 0; exp_lat = TMO_MAX;
            end else if (b_dly >= TMO_MAX) begin
                exp_err = 2'b11; exp_gen = 0; exp_lat = m + 1 + TMO_MAX;
            end else begin
                exp_nb = 1; exp_lat = m + b_dly + 2;
                if (bresp_v != RESP_OKAY) exp_err = 2'b10;
            end
        end
    endtask

    task automatic set_txn(input bit men, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] mask, input bit rs, input logic [4:0] ard,
                           input logic [31:0] rd, input bit gen);
        abt_men = men; abt_write = wr; abt_addr = addr; abt_wdata = wd; abt_mask = mask;
        abt_rsign = rs; abt_ard = ard; abt_rd = rd; abt_gen = gen;
        abt_acsr = 12'($urandom); abt_csr = $urandom; abt_sen = 1'($urandom);
    endtask

    task automatic set_bus(input int ar, input int r, input int aw, input int w, input int b,
                           input int wb, input logic [31:0] rdv, input logic [1:0] rr, input logic [1:0] br);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b; wb_dly = wb;
        rdata_v = rdv; rresp_v = rr; bresp_v = br;
    endtask

    task automatic run_txn(input string tag);
        int k, lat, ar_c, r_c, aw_c, w_c, b_c, wb_c, nar, nr, naw, nw, nb;
        bit r_pend, b_pend, b_start, aw_ok, w_ok, done;
        k = 0; lat = -1; ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; wb_c = 0;
        nar = 0; nr = 0; naw = 0; nw = 0; nb = 0;
        r_pend = 0; b_pend = 0; b_start = 0; aw_ok = 0; w_ok = 0; done = 0;
        predict();
        abt_valid = 1'b1;
        @(posedge clock); #1;
        abt_valid = 1'b0; busy = 1'b1;
        // scramble inputs so anything not latched at accept shows up
        abt_addr = $urandom; abt_wdata = $urandom; abt_rd = $urandom; abt_csr = $urandom;
        abt_ard = 5'($urandom); abt_mask = 2'($urandom); abt_gen = 1'($urandom);
        while (!done && k < 2000) begin
            wbu_ready = wbu_valid && wb_c >= wb_dly;
            if (wbu_valid) begin
                if (lat < 0) lat = k;
                wb_c++; cap_rd = wbu_rd; cap_err = wbu_err; cap_gen = wbu_gen;
                if (wbu_ready) done = 1;
            end
            rvalid = r_pend && r_c >= r_dly;
            rdata  = rvalid ? rdata_v : $urandom;
            rresp  = rvalid ? rresp_v : 2'b00;
            if (r_pend) r_c++;
            if (rvalid && rready) begin nr++; r_pend = 0; end
            bvalid = b_pend && b_c >= b_dly;
            bresp  = bvalid ? bresp_v : 2'b00;
            if (b_pend) b_c++;
            if (bvalid && bready) begin nb++; b_pend = 0; end
            arready = arvalid && ar_c >= ar_dly;
            if (arvalid) begin ar_c++; cap_araddr = araddr; end
            if (arvalid && arready) begin nar++; r_pend = 1; end
            awready = awvalid && aw_c >= aw_dly;
            if (awvalid) aw_c++;
            if (awvalid && awready) begin naw++; aw_ok = 1; end
            wready = wvalid && w_c >= w_dly;
            if (wvalid) begin w_c++; cap_wdata = wdata; cap_wstrb = wstrb; end
            if (wvalid && wready) begin nw++; w_ok = 1; end
            if (aw_ok && w_ok && !b_start) begin b_pend = 1; b_start = 1; end
            @(posedge clock); #1;
            k++;
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; wbu_ready = 0;
        busy = 1'b0;
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_n_ar"}, 32'(nar), 32'(exp_nar));
        check({tag, "_n_r"},  32'(nr),  32'(exp_nr));
        check({tag, "_n_aw"}, 32'(naw), 32'(exp_naw));
        check({tag, "_n_w"},  32'(nw),  32'(exp_nw));
        check({tag, "_n_b"},  32'(nb),  32'(exp_nb));
    endtask

    // per-cycle compare against the model
    always @(negedge clock) begin
        check("abt_ready", 32'(abt_ready), 32'(!busy));
        check("ar_legal", 32'(arvalid && !(busy && exp_bus_rd)), 32'd0);
        check("aww_legal", 32'((awvalid || wvalid) && !(busy && exp_bus_wr)), 32'd0);
        check("wbu_legal", 32'(wbu_valid && !busy), 32'd0);
        if (arvalid) check("araddr", araddr, exp_araddr);
        if (awvalid) check("awaddr", awaddr, exp_araddr);
        if (wvalid) begin
            check("wdata", wdata, exp_wdata);
            check("wstrb", 32'(wstrb), 32'(exp_wstrb));
        end
        if (wbu_valid) begin
            check("wbu_ard", 32'(wbu_ard), 32'(exp_ard));
            check("wbu_gen", 32'(wbu_gen), 32'(exp_gen));
            check("wbu_err", 32'(wbu_err), 32'(exp_err));
            check("wbu_acsr", 32'(wbu_acsr), 32'(exp_acsr));
            check("wbu_csr", wbu_csr, exp_csr);
            check("wbu_sen", 32'(wbu_sen), 32'(exp_sen));
            if (exp_err == 2'b00) check("wbu_rd", wbu_rd, exp_rd);
        end
    end

    initial begin
        bit wr, men;
        logic [1:0] m;
        logic [31:0] a;
        set_bus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_abt_ready", 32'(abt_ready), 32'd1);
        check("rst_wbu_valid", 32'(wbu_valid), 32'd0);
        check("rst_bus_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check("rst_payload", wbu_rd, 32'd0);
        check("rst_gen_sen_err", 32'({wbu_gen, wbu_sen, wbu_err}), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        // model pins
        check("model_lb", model_load(32'h8000_0003, 32'h80FF_FFFF, 2'b01, 1), 32'hFFFF_FF80);
        check("model_lhu", model_load(32'h8000_0002, 32'hBEEF_0000, 2'b10, 0), 32'h0000_BEEF);

        set_txn(0, 0, 32'h0, 32'h0, 2'b00, 0, 5'd5, 32'h1234, 1);
        set_bus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_txn("alu");
        check("lit_alu_rd", cap_rd, 32'h1234);
        check("lit_alu_gen", 32'(cap_gen), 32'd1);

        set_txn(1, 0, 32'h8000_0003, 32'h0, 2'b01, 1, 5'd7, 32'h0, 1);
        set_bus(2, 1, 0, 0, 0, 0, 32'h80FF_FFFF, RESP_OKAY, RESP_OKAY);
        run_txn("lb");
        check("lit_lb_araddr", cap_araddr, 32'h8000_0000);
        check("lit_lb_rd", cap_rd, 32'hFFFF_FF80);

        set_txn(1, 0, 32'h8000_0002, 32'h0, 2'b10, 0, 5'd8, 32'h0, 1);
        set_bus(0, 0, 0, 0, 0, 1, 32'hBEEF_0000, RESP_OKAY, RESP_OKAY);
        run_txn("lhu");
        check("lit_lhu_rd", cap_rd, 32'h0000_BEEF);

        set_txn(1, 1, 32'h8000_0001, 32'hAB, 2'b01, 0, 5'd0, 32'h0, 0);
        set_bus(0, 0, 3, 0, 1, 0, 0, RESP_OKAY, RESP_OKAY);
        run_txn("sb");
        check("lit_sb_wdata", cap_wdata, 32'h0000_AB00);
        check("lit_sb_wstrb", 32'(cap_wstrb), 32'b0010);

        set_txn(1, 1, 32'h8000_0002, 32'h5555, 2'b11, 0, 5'd3, 32'h0, 1);
        set_bus(0, 0, 0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
        run_txn("sw_mis");
        check("lit_sw_mis_err", 32'(cap_err), 32'b01);
        check("lit_sw_mis_gen", 32'(cap_gen), 32'd0);

        set_txn(1, 0, 32'h8000_0100, 32'h0, 2'b11, 0, 5'd9, 32'h0, 1);
        set_bus(1, 2, 0, 0, 0, 0, 32'h1234_5678, RESP_SLVERR, RESP_OKAY);
        run_txn("lw_slverr");
        check("lit_lw_slverr_err", 32'(cap_err), 32'b10);

        set_txn(1, 0, 32'h8000_0200, 32'h0, 2'b11, 0, 5'd10, 32'h0, 1);
        set_bus(TMO_MAX, 0, 0, 0, 0, 4, 32'hDEAD_BEEF, RESP_OKAY, RESP_OKAY);
        run_txn("ar_tmo");
        check("lit_ar_tmo_err", 32'(cap_err), 32'b11);
        check("lit_ar_tmo_gen", 32'(cap_gen), 32'd0);

        set_txn(1, 0, 32'h8000_0204, 32'h0, 2'b11, 0, 5'd11, 32'h0, 1);
        set_bus(TMO_MAX - 1, 0, 0, 0, 0, 0, 32'hCAFE_F00D, RESP_OKAY, RESP_OKAY);
        run_txn("ar_edge");
        check("lit_ar_edge_err", 32'(cap_err), 32'b00);

        set_txn(1, 1, 32'h8000_0300, 32'h77, 2'b11, 0, 5'd12, 32'h0, 0);
        set_bus(0, 0, 1, 2, TMO_MAX, 1, 0, RESP_OKAY, RESP_OKAY);
        run_txn("b_tmo");

        // reset pulse while waiting for read data
        set_txn(1, 0, 32'h8000_0010, 32'h0, 2'b11, 0, 5'd1, 32'h0, 1);
        set_bus(0, 50, 0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
        predict();
        abt_valid = 1'b1;
        @(posedge clock); #1;
        abt_valid = 1'b0; busy = 1'b1; arready = 1'b1;
        @(posedge clock); #1;
        arready = 1'b0;
        check("rst_mid_rready_before", 32'(rready), 32'd1);
        #2 reset = 1'b0; busy = 1'b0;
        #1;
        check("rst_mid_abt_ready", 32'(abt_ready), 32'd1);
        check("rst_mid_rready", 32'(rready), 32'd0);
        check("rst_mid_wbu_valid", 32'(wbu_valid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 300; i++) begin
            men = 1'($urandom_range(0, 3) != 0);
            wr  = 1'($urandom);
            m   = 2'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(m) - 1);
            set_txn(men, wr, a, $urandom, m, 1'($urandom), 5'($urandom), $urandom, 1'($urandom));
            if ($urandom_range(0, 7) == 0)
                set_bus(0, 0, 0, 0, 0, 0, $urandom, RESP_OKAY, RESP_OKAY);
            else
                set_bus($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                        ($urandom_range(0, 5) == 0) ? RESP_SLVERR : RESP_OKAY,
                        ($urandom_range(0, 5) == 0) ? RESP_SLVERR : RESP_OKAY);
            run_txn("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
